// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed 7-segment display scanner.
package display_pkg;

    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 8;
    localparam int SEL_W      = $clog2(MAX_DIGITS);

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    function automatic logic [MAX_DIGITS-1:0] onehot_sel(input logic [SEL_W-1:0] idx);
        return MAX_DIGITS'(1) << idx;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot-rate prescaler: counts 0..SCAN_DIV-1 and flags the last cycle of each slot.
module scan_prescaler
    import display_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_tick;

    assign w_tick = (r_cnt == CW'(SCAN_DIV - 1));
    assign tick   = w_tick;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/display_scanner.sv
// Multi-digit display scanner; new words take effect only at frame boundaries.
// Optional leading-zero blanking: define DISPLAY_SCANNER_ZERO_BLANK_EN.
module display_scanner
    import display_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load,
    input  logic [DIGIT_W*DIGITS-1:0]   bcd_in,
    output logic [DIGIT_W-1:0]          value,
    output logic [DIGITS-1:0]           digit_sel,
    output logic                        frame_done,
    output logic                        pending
);

    localparam int             IW       = $clog2(DIGITS);
    localparam logic [IW-1:0]  LAST_IDX = IW'(DIGITS - 1);

    logic [IW-1:0]               r_idx;
    logic [DIGIT_W*DIGITS-1:0]   r_disp;
    logic [DIGIT_W*DIGITS-1:0]   r_pend_data;
    logic                        r_pend;

    logic                        w_tick;
    logic                        w_boundary;
    bcd_digit_t                  w_value;
    logic [DIGITS-1:0]           w_onehot;

    scan_prescaler #(.SCAN_DIV(SCAN_DIV)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    assign w_boundary = w_tick && (r_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_disp      <= '0;
            r_pend_data <= '0;
            r_pend      <= 1'b0;
        end else begin
            if (w_tick) begin
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IW'(1);
            end
            // A load coinciding with the boundary bypasses the pending register.
            if (w_boundary) begin
                if (load) begin
                    r_disp <= bcd_in;
                end else if (r_pend) begin
                    r_disp <= r_pend_data;
                end
                r_pend <= 1'b0;
            end else if (load) begin
                r_pend_data <= bcd_in;
                r_pend      <= 1'b1;
            end
        end
    end

    assign w_value  = r_disp[DIGIT_W*r_idx +: DIGIT_W];
    assign w_onehot = DIGITS'(onehot_sel(SEL_W'(r_idx)));

`ifdef DISPLAY_SCANNER_ZERO_BLANK_EN
    logic [DIGITS-1:0] w_zero_from;
    logic              w_blank;

    // w_zero_from[k]: nibbles k..DIGITS-1 of the shown word are all zero.
    always_comb begin
        w_zero_from = '0;
        w_zero_from[DIGITS-1] = (r_disp[DIGIT_W*(DIGITS-1) +: DIGIT_W] == '0);
        for (int k = DIGITS - 2; k >= 0; k--) begin
            w_zero_from[k] = (r_disp[DIGIT_W*k +: DIGIT_W] == '0) && w_zero_from[k+1];
        end
    end

    assign w_blank   = (r_idx != '0) && w_zero_from[r_idx];
    assign digit_sel = w_blank ? '0 : w_onehot;
`else
    assign digit_sel = w_onehot;
`endif

    assign value      = w_value;
    assign frame_done = w_boundary;
    assign pending    = r_pend;

endmodule

// File: tb/tb_display_scanner.sv
// Randomized bench for display_scanner against a frame-level reference model.
module tb_display_scanner;

    localparam int D1 = 4, S1 = 3, F1 = D1 * S1;
    localparam int D2 = 2, S2 = 1, F2 = D2 * S2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] bcd_in = '0;

    logic [3:0]  value1, value2;
    logic [3:0]  sel1;
    logic [1:0]  sel2;
    logic        fd1, fd2, pend1, pend2;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state, one set per instance
    int          m1_t, m2_t;
    logic [31:0] m1_disp, m1_pd, m2_disp, m2_pd;
    logic        m1_pend, m2_pend;

    always #5 clk = ~clk;

    display_scanner #(.DIGITS(D1), .SCAN_DIV(S1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .bcd_in     (bcd_in),
        .value      (value1),
        .digit_sel  (sel1),
        .frame_done (fd1),
        .pending    (pend1)
    );

    display_scanner #(.DIGITS(D2), .SCAN_DIV(S2)) dut_fast (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .bcd_in     (bcd_in[7:0]),
        .value      (value2),
        .digit_sel  (sel2),
        .frame_done (fd2),
        .pending    (pend2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic l, input logic [31:0] d, input logic rn, input int frame,
                              inout int t, inout logic [31:0] disp, inout logic [31:0] pd,
                              inout logic pend);
        if (!rn) begin
            t = 0; disp = '0; pd = '0; pend = 1'b0;
        end else begin
            if ((t % frame) == frame - 1) begin
                if (l) disp = d;
                else if (pend) disp = pd;
                pend = 1'b0;
            end else if (l) begin
                pd = d;
                pend = 1'b1;
            end
            t++;
        end
    endtask

    function automatic logic [31:0] exp_val(input logic [31:0] disp, input int slot);
        return (disp >> (4 * slot)) & 32'hF;
    endfunction

    function automatic logic [31:0] exp_sel(input logic [31:0] disp, input int slot);
        logic [31:0] s;
        s = 32'd1 << slot;
`ifdef DISPLAY_SCANNER_ZERO_BLANK_EN
        if (slot >= 1 && (disp >> (4 * slot)) == 0) s = 0;
`endif
        return s;
    endfunction

    task automatic step(input logic l, input logic [15:0] d, input logic rn);
        int sl1, sl2;
        @(negedge clk);
        load = l; bcd_in = d; rst_n = rn;
        @(posedge clk);
        model_step(l, {16'h0, d}, rn, F1, m1_t, m1_disp, m1_pd, m1_pend);
        model_step(l, {24'h0, d[7:0]}, rn, F2, m2_t, m2_disp, m2_pd, m2_pend);
        #1;
        sl1 = (m1_t / S1) % D1;
        sl2 = (m2_t / S2) % D2;
        check_eq("value", 32'(value1), exp_val(m1_disp, sl1));
        check_eq("digit_sel", 32'(sel1), exp_sel(m1_disp, sl1));
        check_eq("frame_done", 32'(fd1), 32'((m1_t % F1) == F1 - 1));
        check_eq("pending", 32'(pend1), 32'(m1_pend));
        check_eq("fast_value", 32'(value2), exp_val(m2_disp, sl2));
        check_eq("fast_digit_sel", 32'(sel2), exp_sel(m2_disp, sl2));
        check_eq("fast_frame_done", 32'(fd2), 32'((m2_t % F2) == F2 - 1));
        check_eq("fast_pending", 32'(pend2), 32'(m2_pend));
    endtask

    initial begin
        logic [15:0] d;
        m1_t = 0; m1_disp = '0; m1_pd = '0; m1_pend = 1'b0;
        m2_t = 0; m2_disp = '0; m2_pd = '0; m2_pend = 1'b0;

        // reset, then one idle frame
        step(1'b0, 16'h0, 1'b0);
        step(1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 14; i++) step(1'b0, 16'h0, 1'b1);

        // mid-frame load, held until the boundary
        step(1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b1);
        step(1'b1, 16'h4321, 1'b1);
        for (int i = 0; i < 2 * F1; i++) step(1'b0, 16'h0, 1'b1);

        // load exactly on the boundary cycle
        while ((m1_t % F1) != F1 - 1) step(1'b0, 16'h0, 1'b1);
        step(1'b1, 16'h9876, 1'b1);
        for (int i = 0; i < F1; i++) step(1'b0, 16'h0, 1'b1);

        // back-to-back loads: latest wins
        step(1'b1, 16'h1111, 1'b1);
        step(1'b1, 16'h2222, 1'b1);
        for (int i = 0; i < 2 * F1; i++) step(1'b0, 16'h0, 1'b1);

        // reset mid-frame with a pending word
        while (((m1_t / S1) % D1) != 1) step(1'b0, 16'h0, 1'b1);
        step(1'b1, 16'h5555, 1'b1);
        while (((m1_t / S1) % D1) != 2) step(1'b0, 16'h0, 1'b1);
        step(1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 2 * F1; i++) step(1'b0, 16'h0, 1'b1);

        // leading-zero patterns
        while ((m1_t % F1) != F1 - 1) step(1'b0, 16'h0, 1'b1);
        step(1'b1, 16'h0050, 1'b1);
        for (int i = 0; i < F1; i++) step(1'b0, 16'h0, 1'b1);
        step(1'b1, 16'h0000, 1'b1);
        for (int i = 0; i < 2 * F1; i++) step(1'b0, 16'h0, 1'b1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            d = 16'($urandom);
            if ($urandom_range(0, 2) == 0) d[15:8] = 8'h00;
            if ($urandom_range(0, 3) == 0) d[7:4] = 4'h0;
            step($urandom_range(0, 7) == 0, d, $urandom_range(0, 299) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
